// File: rtl/reg_arb_pkg.sv
// Shared constants and types for the register-file port arbiter.
// Used by reg_port_arbiter and reg_arb_starve_cnt.
package reg_arb_pkg;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned REG_DATA_W = 8;
    localparam int unsigned REG_COUNT  = 16;
    localparam logic [REG_ADDR_W-1:0] DST_REG = 4'd15;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } arb_port_e;

endpackage

// File: rtl/reg_arb_starve_cnt.sv
// Saturating wait counter for the debug port.
// Flags starvation once the count reaches STARVE_LIMIT.
module reg_arb_starve_cnt
    import reg_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic starve
);

    logic [REG_ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starve = (cnt >= REG_ADDR_W'(STARVE_LIMIT));

endmodule

// File: rtl/reg_port_arbiter.sv
// Two-port req/gnt arbiter in front of the 16x8 register file.
// Define REG_ARB_STARVE_EN to enable the port-1 starvation override.
module reg_port_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [REG_ADDR_W-1:0] addr0,
    input  logic [REG_DATA_W-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [REG_ADDR_W-1:0] addr1,
    input  logic [REG_DATA_W-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [REG_DATA_W-1:0] rdata0,
    output logic [REG_DATA_W-1:0] rdata1,
    output logic [REG_ADDR_W-1:0] rf_reg_in,
    output logic [REG_DATA_W-1:0] rf_data_in,
    output logic                  rf_write_ctrl,
    input  logic [REG_DATA_W-1:0] rf_data_out
);

    logic      starve;
    logic      rd_pend;
    arb_port_e rd_owner;

`ifdef REG_ARB_STARVE_EN
    reg_arb_starve_cnt #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (req1 & ~gnt1),
        .clr   (gnt1 | ~req1),
        .starve(starve)
    );
`else
    logic [31:0] unused_starve_limit;
    assign unused_starve_limit = 32'(STARVE_LIMIT);
    assign starve = 1'b0;
`endif

    // Grants are gated by reset so a write cannot slip through mid-reset.
    assign gnt1 = RST_N & req1 & (~req0 | starve);
    assign gnt0 = RST_N & req0 & ~gnt1;

    always_comb begin
        rf_reg_in     = '0;
        rf_data_in    = '0;
        rf_write_ctrl = 1'b0;
        unique case (1'b1)
            gnt0: begin
                rf_reg_in     = addr0;
                rf_data_in    = wdata0;
                rf_write_ctrl = we0;
            end
            gnt1: begin
                rf_reg_in     = addr1;
                rf_data_in    = wdata1;
                rf_write_ctrl = we1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_pend  <= 1'b0;
            rd_owner <= PORT_CORE;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            rd_pend <= (gnt0 & ~we0) | (gnt1 & ~we1);
            if (gnt0 && !we0) begin
                rd_owner <= PORT_CORE;
                rdata0   <= rf_data_out;
            end
            if (gnt1 && !we1) begin
                rd_owner <= PORT_DBG;
                rdata1   <= rf_data_out;
            end
        end
    end

    assign rvalid0 = rd_pend & (rd_owner == PORT_CORE);
    assign rvalid1 = rd_pend & (rd_owner == PORT_DBG);

endmodule
